// File: rtl/jericalla.sv
// jericalla: single-cycle datapath, ROM operand op RAM operand through a 32-bit ALU, registered result + zero flag.
// Optional RAM write-back of the result is compiled in by defining JERICALLA_WB_EN.

// Preload-only ROM; its init write port is tied off by the datapath.
module jericalla_rom #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_rom [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_rom[waddr] <= wdata;
        end
    end

    assign rdata = mem_rom[raddr];
endmodule

// RAM with asynchronous read, so a same-address write is seen only by later reads.
module jericalla_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_ram [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_ram[waddr] <= wdata;
        end
    end

    assign rdata = mem_ram[raddr];
endmodule

module jericalla #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [4+2*ADDR_W+1-1:0]     instruccion,
    output logic [DATA_W-1:0]           salida,
    output logic                        ZF_J
);
    localparam int unsigned OP_W    = 4;
    localparam int unsigned INSTR_W = OP_W + 2 * ADDR_W + 1;

    localparam logic [OP_W-1:0] OP_AND = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLT = 4'b0111;
    localparam logic [OP_W-1:0] OP_NOR = 4'b1100;

    logic [OP_W-1:0]   alu_op;
    logic [ADDR_W-1:0] rom_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic              wb;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;
    logic              ram_we;

    assign alu_op   = instruccion[INSTR_W-1 -: OP_W];
    assign rom_addr = instruccion[2*ADDR_W -: ADDR_W];
    assign ram_addr = instruccion[ADDR_W:1];
    assign wb       = instruccion[0];

`ifdef JERICALLA_WB_EN
    // Reset cycles never write, so a pending write-back is dropped.
    assign ram_we = wb & ~rst;
`else
    logic unused_wb;
    assign unused_wb = wb;
    assign ram_we    = 1'b0;
`endif

    jericalla_rom #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ROM_J (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .raddr (rom_addr),
        .rdata (op_a)
    );

    jericalla_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) RAM_J (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_addr),
        .wdata (result),
        .raddr (ram_addr),
        .rdata (op_b)
    );

    // ALU; unassigned opcodes produce zero.
    always_comb begin
        result = '0;
        case (alu_op)
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_ADD:  result = op_a + op_b;
            OP_SUB:  result = op_a - op_b;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_NOR:  result = ~(op_a | op_b);
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            salida <= '0;
            ZF_J   <= 1'b1;
        end else begin
            salida <= result;
            ZF_J   <= (result == '0);
        end
    end
endmodule

// File: tb/tb_jericalla.sv
// Scoreboard bench for jericalla: reference memories + ALU model, expected results queued at drive time.
// Honors JERICALLA_WB_EN the same way the design does.
module tb_jericalla;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [16:0]       instruccion;
    logic [DATA_W-1:0] salida;
    logic              ZF_J;

    always #5 clk = ~clk;

    jericalla #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruccion (instruccion),
        .salida      (salida),
        .ZF_J        (ZF_J)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        zf;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rom_m [DEPTH];
    logic [31:0] ram_m [DEPTH];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [16:0] mk(input logic [3:0] op, input logic [5:0] ra, input logic [5:0] wa, input logic w);
        return {op, ra, wa, w};
    endfunction

    // Drive one instruction, queue its expectation, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic [16:0] ins,
                        input bit use_fixed, input logic [31:0] fixed);
        exp_t        e;
        logic [31:0] mres;
        @(negedge clk);
        rst         = r;
        instruccion = ins;
        mres = alu(ins[16:13], rom_m[ins[12:7]], ram_m[ins[6:1]]);
        if (r) begin
            e.res = 32'd0;
            e.zf  = 1'b1;
        end else begin
            e.res = use_fixed ? fixed : mres;
            e.zf  = (e.res == 32'd0);
        end
`ifdef JERICALLA_WB_EN
        if (!r && ins[0]) ram_m[ins[6:1]] = mres;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".salida"}, salida, e.res);
        check({tag, ".zf"}, {31'd0, ZF_J}, {31'd0, e.zf});
    endtask

    initial begin
        logic [3:0]  ops [7];
        logic [3:0]  op;
        logic        r;
        logic [31:0] wb_second;

        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111};
        rst         = 1'b1;
        instruccion = 17'h1FFFF;

        for (int i = 0; i < DEPTH; i++) begin
            rom_m[i] = $urandom;
            ram_m[i] = $urandom;
        end
        rom_m[0]  = 32'h0;        ram_m[0]  = 32'h5;
        rom_m[63] = 32'hF0F0F0F0; ram_m[63] = 32'h0FF00FF0;
        rom_m[1]  = 32'hFFFFFFFF; ram_m[1]  = 32'h1;
        rom_m[2]  = 32'h80000000; ram_m[2]  = 32'h00000001;
        for (int i = 0; i < DEPTH; i++) begin
            dut.ROM_J.mem_rom[i] = rom_m[i];
            dut.RAM_J.mem_ram[i] = ram_m[i];
        end

        step("reset0", 1'b1, 17'h1FFFF, 1'b1, 32'h0);
        step("reset1", 1'b1, 17'h1FFFF, 1'b1, 32'h0);
        check("reset.ram63", dut.RAM_J.mem_ram[63], 32'h0FF00FF0);

        step("and0",  1'b0, 17'b00000000000000000, 1'b1, 32'h00000000);
        step("and63", 1'b0, 17'b00001111111111110, 1'b1, 32'h00F000F0);
        step("or63",  1'b0, 17'b00011111111111110, 1'b1, 32'hFFF0FFF0);
        step("addwrap", 1'b0, mk(4'b0010, 6'd1, 6'd1, 1'b0), 1'b1, 32'h00000000);
        step("slt_neg", 1'b0, mk(4'b0111, 6'd2, 6'd2, 1'b0), 1'b1, 32'h00000001);
        step("sub", 1'b0, mk(4'b0110, 6'd0, 6'd0, 1'b0), 1'b1, 32'hFFFFFFFB);
        step("nor", 1'b0, mk(4'b1100, 6'd63, 6'd63, 1'b0), 1'b1, 32'h000F000F);

`ifdef JERICALLA_WB_EN
        wb_second = 32'hF0F0F0F0;
`else
        wb_second = 32'h00000000;
`endif
        step("wb_or",  1'b0, mk(4'b0001, 6'd63, 6'd0, 1'b1), 1'b1, 32'hF0F0F0F5);
        step("wb_and", 1'b0, mk(4'b0000, 6'd63, 6'd0, 1'b0), 1'b1, wb_second);

        // Write-back then immediate reuse of the same RAM word.
        step("rdw_add", 1'b0, mk(4'b0010, 6'd63, 6'd3, 1'b1), 1'b0, 32'h0);
        step("rdw_use", 1'b0, mk(4'b0001, 6'd0, 6'd3, 1'b0), 1'b0, 32'h0);

        // Reset in mid-stream must drop the write-back it overlaps.
        step("midrst", 1'b1, mk(4'b0001, 6'd1, 6'd5, 1'b1), 1'b0, 32'h0);
        check("midrst.ram5", dut.RAM_J.mem_ram[5], ram_m[5]);

        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 6)];
            r  = ($urandom_range(0, 11) == 0);
            step("rand", r, mk(op, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1))), 1'b0, 32'h0);
        end

        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ram[%0d]", i), dut.RAM_J.mem_ram[i], ram_m[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
